// File: rtl/drop_fifo_ctrl.sv
// drop_fifo_ctrl
// ---------------------------------------------------------------------------
// Packet-level pointer controller for a dual-port packet buffer.
//
// Framed words (in_first / in_last) are written speculatively at wr_ptr.
// A packet is published to the read side only when its last word arrives.
// cmt_ptr then moves to the end of the packet. A drop request, an overflow or
// a framing error discards the partial packet by pulling wr_ptr back to
// cmt_ptr. The read side never looks past cmt_ptr.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         asynchronous active-low reset
//   in_data     write word
//   in_wr       word valid this cycle
//   in_first    word is first of packet
//   in_last     word is last of packet
//   drop_pkt    discard the packet currently being written
//   fiforead    read request
//   mem_addra   port A (write) address, registered
//   mem_dina    port A write data, registered
//   mem_wea     port A write enable, registered
//   mem_addrb   port B (read) address, combinational from rd_ptr
//   valid_data  port B output holds a valid read word this cycle
//   fill_level  committed words not yet read
//   commit_cnt  packets committed (saturating)
//   drop_cnt    packets dropped (saturating)
//   proto_err   one-cycle pulse on a framing error
//
// Port A writes lag the accepted word by one cycle. A single-word packet can
// therefore be read on the very cycle its word lands in memory. Port B must
// be write-first, or bypass port A, when the two addresses collide.
// ---------------------------------------------------------------------------

module drop_fifo_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 72,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_wr,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              drop_pkt,
    input  logic              fiforead,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addrb,
    output logic              valid_data,
    output logic [ADDR_W:0]   fill_level,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              proto_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PKT     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    // Occupancy at which every buffer slot holds unread data.
    localparam logic [ADDR_W:0]  FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cmt_ptr_q, cmt_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q;

    logic              wea_d;
    logic [ADDR_W-1:0] addra_d;
    logic              perr_d;
    logic              commit_evt;
    logic              drop_evt;
    logic              rd_en;

    logic [ADDR_W:0]   wr_level;
    logic [ADDR_W:0]   cmt_level;
    logic              wr_full;
    logic              cmt_full;

    // Occupancy is measured against rd_ptr. A read in the same cycle does not
    // free a slot until the next cycle, so the check is conservative.
    assign wr_level  = wr_ptr_q - rd_ptr_q;
    assign cmt_level = cmt_ptr_q - rd_ptr_q;
    assign wr_full   = (wr_level == FULL_LVL);
    assign cmt_full  = (cmt_level == FULL_LVL);

    // Read uses the pre-update cmt_ptr. A packet committed this cycle becomes
    // visible next cycle.
    assign rd_en      = fiforead && (rd_ptr_q != cmt_ptr_q);
    assign mem_addrb  = rd_ptr_q[ADDR_W-1:0];
    assign fill_level = cmt_level;

    // ------------------------------------------------------------------
    // Write-side FSM and pointer next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        wea_d      = 1'b0;
        addra_d    = wr_ptr_q[ADDR_W-1:0];
        perr_d     = 1'b0;
        commit_evt = 1'b0;
        drop_evt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_wr) begin
                    if (!in_first) begin
                        // Stray word outside a packet.
                        perr_d = 1'b1;
                    end else if (wr_full) begin
                        // No room even for the first word: drop the whole packet.
                        drop_evt = 1'b1;
                        state_d  = in_last ? ST_IDLE : ST_DISCARD;
                    end else begin
                        wea_d    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (in_last) begin
                            cmt_ptr_d  = wr_ptr_q + PTR_ONE;
                            commit_evt = 1'b1;
                        end else begin
                            state_d = ST_PKT;
                        end
                    end
                end
            end

            ST_PKT: begin
                if (drop_pkt) begin
                    wr_ptr_d = cmt_ptr_q;
                    drop_evt = 1'b1;
                    state_d  = (in_wr && in_last) ? ST_IDLE : ST_DISCARD;
                end else if (in_wr && in_first) begin
                    // A new first word aborts the partial packet. The new
                    // word restarts at cmt_ptr.
                    perr_d   = 1'b1;
                    drop_evt = 1'b1;
                    if (cmt_full) begin
                        wr_ptr_d = cmt_ptr_q;
                        state_d  = in_last ? ST_IDLE : ST_DISCARD;
                    end else begin
                        wea_d    = 1'b1;
                        addra_d  = cmt_ptr_q[ADDR_W-1:0];
                        wr_ptr_d = cmt_ptr_q + PTR_ONE;
                        if (in_last) begin
                            cmt_ptr_d  = cmt_ptr_q + PTR_ONE;
                            commit_evt = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end else if (in_wr) begin
                    if (wr_full) begin
                        // Overflow behaves exactly like a drop request.
                        wr_ptr_d = cmt_ptr_q;
                        drop_evt = 1'b1;
                        state_d  = in_last ? ST_IDLE : ST_DISCARD;
                    end else begin
                        wea_d    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (in_last) begin
                            cmt_ptr_d  = wr_ptr_q + PTR_ONE;
                            commit_evt = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end
                end
            end

            ST_DISCARD: begin
                if (in_wr && in_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, pointers and registered memory port A
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
            mem_wea   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
            valid_data <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            mem_wea <= wea_d;
            // Hold address/data between writes to avoid needless toggling.
            if (wea_d) begin
                mem_addra <= addra_d;
                mem_dina  <= in_data;
            end
            valid_data <= rd_en;
            proto_err  <= perr_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (commit_evt && !(&commit_cnt)) begin
                commit_cnt <= commit_cnt + CNT_ONE;
            end
            if (drop_evt && !(&drop_cnt)) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/drop_fifo_ctrl.md
Name: drop_fifo_ctrl

Overview:
- Packet-level pointer controller for the 72-bit dual-port packet buffer.
- Accepts a framed word stream (first/last markers) and writes it to the buffer speculatively.
- On last word it commits the packet; on drop request or overflow it discards the packet by rolling the write pointer back.
- The read side only sees committed packets. The block drives the memory's port A (write) and port B (read) directly.

Parameters:
- ADDR_W, 8, buffer address width; depth = 2^ADDR_W words.
- DATA_W, 72, word width.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clk.
- in_data  in  DATA_W  write word.
- in_wr  in  1  word valid this cycle.
- in_first  in  1  word is first of packet.
- in_last  in  1  word is last of packet.
- drop_pkt  in  1  discard the packet currently being written.
- fiforead  in  1  read request.
- mem_addra  out  ADDR_W  port A address.
- mem_dina  out  DATA_W  port A data.
- mem_wea  out  1  port A write enable.
- mem_addrb  out  ADDR_W  port B address.
- valid_data  out  1  mem doutb holds a valid read word this cycle.
- fill_level  out  ADDR_W+1  committed words not yet read.
- commit_cnt  out  CNT_W  packets committed; saturating.
- drop_cnt  out  CNT_W  packets dropped; saturating.
- proto_err  out  1  one-cycle pulse on framing error.

Behaviour:
- Pointers:
  - wr_ptr (speculative), cmt_ptr (end of last committed packet) and rd_ptr are each ADDR_W+1 bits; the MSB is the wrap bit.
  - Memory addresses use the low ADDR_W bits.
  - Wrap from 2^ADDR_W-1 to 0 is natural modulo arithmetic.
- Reset (rst=0): all pointers, counters, mem_wea, valid_data and proto_err are 0; FSM enters IDLE. mem_addra, mem_addrb and mem_dina reset to 0.
- Write FSM, states IDLE / PKT / DISCARD:
  - IDLE:
    - in_wr & in_first: write the word and go to PKT.
    - Same word also has in_last: commit immediately and stay in IDLE.
    - in_wr without in_first: word ignored, proto_err pulses.
  - PKT:
    - in_wr: write the word at wr_ptr; wr_ptr increments.
    - in_wr & in_last: cmt_ptr <= wr_ptr+1, commit_cnt++, go to IDLE.
  - DISCARD: ignore words until in_wr & in_last, then go to IDLE. No writes occur.
- Write timing: the write is registered. mem_wea, mem_addra and mem_dina assert one cycle after the accepted word.
- Drop:
  - drop_pkt=1 in PKT (with or without a word, including the last word's cycle): wr_ptr <= cmt_ptr, drop_cnt++, and no write for that cycle's word.
  - Next state is IDLE if this cycle carried in_last, otherwise DISCARD.
  - drop_pkt in IDLE/DISCARD: no effect.
- Overflow:
  - An accepted word when wr_ptr - rd_ptr == 2^ADDR_W is treated exactly as drop_pkt.
  - The buffer never overwrites unread data.
- Framing error: in_first while in PKT.
  - Roll back the partial packet and pulse proto_err; drop_cnt++.
  - The word starts a new packet at cmt_ptr and the FSM stays in PKT, or goes to IDLE with commit if in_last is also set.
- Read side:
  - A read occurs when fiforead & (rd_ptr != cmt_ptr): mem_addrb = rd_ptr (combinational), rd_ptr increments.
  - valid_data = registered read condition, so doutb is valid one cycle after the request.
  - fiforead while empty is ignored (valid_data=0).
- Simultaneous commit and read: the read compares against the pre-update cmt_ptr. The new packet becomes readable the cycle after commit.
- fill_level = cmt_ptr - rd_ptr, registered-pointer based. Speculative words are never counted.
- Counters saturate at all-ones.
- Reset mid-packet: the partial packet is lost and all pointers return to 0.

Test Plan:
- 4-word packet (first on word 0, last on word 3) at ADDR_W=8 -> mem_wea on 4 cycles, addresses 0..3; commit_cnt=1; fill_level=4 the cycle after the last word; fiforead for 4 cycles -> valid_data 4 cycles with one-cycle latency, then fill_level=0.
- 3-word packet with drop_pkt on word 2 (no last), then last word -> no write for word 2; wr_ptr back to 0; drop_cnt=1; fill_level stays 0; next packet is written starting at address 0.
- Fill with 255 committed words unread, then a 2-word packet -> first word written at address 255, second overflows; packet rolled back; drop_cnt=1; fill_level=255; no overwrite of address 0.
- Packet crossing the wrap (cmt_ptr=254, 4 words) -> writes to 254, 255, 0, 1; read data returned in order; fill_level correct across the MSB toggle.
- Word without first in IDLE, then first twice without last -> proto_err pulses twice; drop_cnt=1; the second packet commits correctly.
- Commit and fiforead in the same cycle on an empty buffer -> valid_data=0 that cycle; read the next cycle succeeds. Assert rst=0 mid-packet -> all outputs are 0 immediately (asynchronous).
